// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;
   localparam int BYTE_W      = 8;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_DONE  = 3'd3,
      S_GAP        = 3'd4
   } arb_state_t;
endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module uart_rr_picker #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  win,
   output logic             valid
);
   always_comb begin
      win   = '0;
      valid = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!valid && req[(int'(ptr) + k) % NREQ]) begin
            win[(int'(ptr) + k) % NREQ] = 1'b1;
            valid                       = 1'b1;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte sender among NREQ sources.
// Optional watchdog on the sender handshake: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NREQ         = 4,
   parameter int GAP_TICKS    = 16,
   parameter int ACK_TIMEOUT  = 64,
   parameter int DONE_TIMEOUT = 256
) (
   input  logic                   baudclk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        lock,
   input  logic [BYTE_W*NREQ-1:0] req_data,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        grant,
   output logic [BYTE_W-1:0]      tx_data,
   output logic                   tx_en,
   input  logic                   tx_status,
   output logic                   busy,
   output logic                   err,
   output logic [2:0]             dbg_state
);
   // Handshakes: a requester holds req (and its byte) until a one-cycle ack
   // says the byte was latched. Toward the sender, tx_en stays high until the
   // synchronized tx_status shows busy; the frame ends when it reads idle again.
   localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GAP_W  = $clog2(GAP_TICKS + 1);
   localparam int WD_MAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
   localparam int WD_W   = $clog2(WD_MAX + 1);

   arb_state_t              state, state_d;
   logic [PTR_W-1:0]        ptr, ptr_d, win_idx, next_ptr;
   logic [GAP_W-1:0]        gap_cnt, gap_d;
   logic [WD_W-1:0]         wd_cnt, wd_d;
   logic [NREQ-1:0]         ack_d, grant_d, win;
   logic [BYTE_W-1:0]       tx_data_d, win_byte, own_byte;
   logic                    tx_en_d, err_q, err_d, win_valid, st_s;
   logic [SYNC_STAGES-1:0]  st_sync;

   always_ff @(posedge baudclk or posedge reset) begin
      if (reset) st_sync <= '1;
      else       st_sync <= {st_sync[SYNC_STAGES-2:0], tx_status};
   end
   assign st_s = st_sync[SYNC_STAGES-1];

   uart_rr_picker #(.NREQ(NREQ), .PTR_W(PTR_W)) u_picker (
      .req   (req),
      .ptr   (ptr),
      .win   (win),
      .valid (win_valid)
   );

   always_comb begin
      win_byte = '0;
      own_byte = '0;
      win_idx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win[i]) begin
            win_byte = req_data[i*BYTE_W +: BYTE_W];
            win_idx  = PTR_W'(i);
         end
         if (grant[i]) own_byte = req_data[i*BYTE_W +: BYTE_W];
      end
      next_ptr = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
   end

   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      gap_d     = gap_cnt;
      wd_d      = wd_cnt;
      ack_d     = '0;
      grant_d   = grant;
      tx_data_d = tx_data;
      tx_en_d   = tx_en;
      err_d     = err_q;
      case (state)
         S_IDLE: begin
            if (win_valid && st_s) begin
               grant_d   = win;
               ack_d     = win;
               tx_data_d = win_byte;
               tx_en_d   = 1'b1;
               ptr_d     = next_ptr;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            wd_d    = '0;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (!st_s) begin
               tx_en_d = 1'b0;
               wd_d    = '0;
               state_d = S_WAIT_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (wd_cnt == WD_W'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               tx_en_d = 1'b0;
               grant_d = '0;
               gap_d   = '0;
               state_d = S_GAP;
            end else begin
               wd_d = wd_cnt + 1'b1;
            end
`endif
         end
         S_WAIT_DONE: begin
            if (st_s) begin
               gap_d   = '0;
               state_d = S_GAP;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (wd_cnt == WD_W'(DONE_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               grant_d = '0;
               gap_d   = '0;
               state_d = S_GAP;
            end else begin
               wd_d = wd_cnt + 1'b1;
            end
`endif
         end
         S_GAP: begin
            if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
               // A timed-out owner has grant cleared, so its lock cannot match.
               if (|(grant & lock & req)) begin
                  ack_d     = grant;
                  tx_data_d = own_byte;
                  tx_en_d   = 1'b1;
                  state_d   = S_LOAD;
               end else begin
                  grant_d = '0;
                  state_d = S_IDLE;
               end
            end else begin
               gap_d = gap_cnt + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge baudclk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         ptr     <= '0;
         gap_cnt <= '0;
         wd_cnt  <= '0;
         ack     <= '0;
         grant   <= '0;
         tx_data <= '0;
         tx_en   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         gap_cnt <= gap_d;
         wd_cnt  <= wd_d;
         ack     <= ack_d;
         grant   <= grant_d;
         tx_data <= tx_data_d;
         tx_en   <= tx_en_d;
         err_q   <= err_d;
      end
   end

   assign err       = err_q;
   assign busy      = (state != S_IDLE);
   assign dbg_state = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART sender model.
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   localparam int GAP  = 16;

   logic             baudclk = 1'b0;
   logic             reset = 1'b1;
   logic [NREQ-1:0]  req = '0;
   logic [NREQ-1:0]  lock = '0;
   logic [8*NREQ-1:0] req_data = '0;
   logic [NREQ-1:0]  ack, grant;
   logic [7:0]       tx_data;
   logic             tx_en, busy, err;
   logic             tx_status = 1'b1;
   logic [2:0]       dbg_state;
   logic             sender_on = 1'b1;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 baudclk = ~baudclk;

   uart_tx_arbiter #(.NREQ(NREQ), .GAP_TICKS(GAP), .ACK_TIMEOUT(64), .DONE_TIMEOUT(256)) dut (
      .baudclk   (baudclk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .req_data  (req_data),
      .ack       (ack),
      .grant     (grant),
      .tx_data   (tx_data),
      .tx_en     (tx_en),
      .tx_status (tx_status),
      .busy      (busy),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // Sender: goes busy 2 cycles after seeing tx_en, idle 160 cycles later.
   initial forever begin
      @(posedge baudclk); #2;
      if (tx_en && sender_on) begin
         repeat (2) @(posedge baudclk);
         #2 tx_status = 1'b0;
         got_q.push_back(tx_data);
         repeat (160) @(posedge baudclk);
         #2 tx_status = 1'b1;
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge baudclk);
      total_cnt++;
      if ({tx_en, tx_data, grant, ack, busy, err} !== '0)
         $display("FAIL reset_outputs: got %h want 0", {tx_en, tx_data, grant, ack, busy, err});
      else pass_cnt++;
      total_cnt++;
      if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
      else pass_cnt++;
      reset = 1'b0;
      repeat (3) @(negedge baudclk);
      total_cnt++;
      if ({tx_en, grant, busy} !== '0) $display("FAIL idle_after_reset: got %h want 0", {tx_en, grant, busy});
      else pass_cnt++;
   endtask

   task automatic test_single();
      int n;
      req_data[7:0] = 8'h55;
      req[0] = 1'b1;
      exp_q.push_back(8'h55);
      @(negedge baudclk);
      total_cnt++;
      if ({ack, grant, tx_en} !== {4'b0001, 4'b0001, 1'b1})
         $display("FAIL single_ack_latency: got ack=%b grant=%b tx_en=%b want 0001 0001 1", ack, grant, tx_en);
      else pass_cnt++;
      total_cnt++;
      if (tx_data !== 8'h55) $display("FAIL single_tx_data: got %h want 55", tx_data);
      else pass_cnt++;
      req[0] = 1'b0;
      n = 0;
      while (tx_status !== 1'b0 && n < 100) begin @(negedge baudclk); n++; end
      total_cnt++;
      if (n >= 100) $display("FAIL single_sender_busy: timeout after %0d cycles", n);
      else pass_cnt++;
      // Two sync stages then the registered drop: high for two more cycles.
      @(negedge baudclk); n = tx_en;
      @(negedge baudclk); n = n + tx_en;
      @(negedge baudclk);
      total_cnt++;
      if (n != 2 || tx_en !== 1'b0) $display("FAIL single_tx_en_hold: high=%0d then %b want 2 then 0", n, tx_en);
      else pass_cnt++;
      n = 0;
      while (tx_status !== 1'b1 && n < 400) begin @(negedge baudclk); n++; end
      // GAP+2 after the first edge sampling idle, i.e. GAP+3 edges from here.
      n = 0;
      while (busy === 1'b1 && n < 200) begin @(negedge baudclk); n++; end
      total_cnt++;
      if (n != GAP + 3) $display("FAIL single_busy_release: got %0d cycles want %0d", n, GAP + 3);
      else pass_cnt++;
      total_cnt++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0])
         $display("FAIL single_byte: got n=%0d byte=%h want 55", got_q.size(), got_q.size() ? got_q[0] : 8'hxx);
      else pass_cnt++;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_round_robin();
      int rem[NREQ];
      int n_ack, cyc, last_t, min_gap;
      reset = 1'b1; @(negedge baudclk); reset = 1'b0; @(negedge baudclk);
      rem = '{2, 1, 1, 1};
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      foreach (rem[i]) exp_q.push_back(8'hA0 + 8'(i));
      exp_q.push_back(8'hA0);
      req = 4'b1111;
      n_ack = 0; cyc = 0; last_t = -1; min_gap = 100000;
      while (n_ack < 5 && cyc < 3000) begin
         @(negedge baudclk); cyc++;
         for (int i = 0; i < NREQ; i++) if (ack[i]) begin
            if (last_t >= 0 && cyc - last_t < min_gap) min_gap = cyc - last_t;
            last_t = cyc; n_ack++; rem[i]--;
            if (rem[i] == 0) req[i] = 1'b0;
         end
      end
      total_cnt++;
      if (n_ack != 5) $display("FAIL rr_ack_count: got %0d want 5", n_ack);
      else pass_cnt++;
      total_cnt++;
      if (min_gap < GAP + 4) $display("FAIL rr_ack_spacing: got %0d want >= %0d", min_gap, GAP + 4);
      else pass_cnt++;
      cyc = 0;
      while ((got_q.size() < 5 || busy) && cyc < 1000) begin @(negedge baudclk); cyc++; end
      req = '0;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL rr_byte%0d: got nothing want %h", i, exp_q[0]);
         else if (got_q[0] !== exp_q[0]) $display("FAIL rr_byte%0d: got %h want %h", i, got_q[0], exp_q[0]);
         else pass_cnt++;
         if (got_q.size() != 0) void'(got_q.pop_front());
         void'(exp_q.pop_front());
      end
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_lock();
      int n2, cyc;
      logic done0;
      req_data[23:16] = 8'hB0;
      req_data[7:0]   = 8'hC0;
      exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hC0};
      lock[2] = 1'b1;
      req = 4'b0101;
      n2 = 0; cyc = 0; done0 = 1'b0;
      while (!done0 && cyc < 3000) begin
         @(negedge baudclk); cyc++;
         if (ack[2]) begin
            n2++;
            if (n2 == 1) req_data[23:16] = 8'hB1;
            if (n2 == 2) req_data[23:16] = 8'hB2;
            if (n2 == 3) begin lock[2] = 1'b0; req[2] = 1'b0; end
         end
         if (ack[0]) begin req[0] = 1'b0; done0 = 1'b1; end
      end
      cyc = 0;
      while ((got_q.size() < 4 || busy) && cyc < 1000) begin @(negedge baudclk); cyc++; end
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL lock_byte%0d: got nothing want %h", i, exp_q[0]);
         else if (got_q[0] !== exp_q[0]) $display("FAIL lock_byte%0d: got %h want %h", i, got_q[0], exp_q[0]);
         else pass_cnt++;
         if (got_q.size() != 0) void'(got_q.pop_front());
         void'(exp_q.pop_front());
      end
      req = '0; lock = '0;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_withdraw();
      int cyc;
      logic saw_ack, saw_en, saw_busy;
      req_data[31:24] = 8'hD3;
      exp_q.push_back(8'hD3);
      req[3] = 1'b1;
      cyc = 0;
      while (dbg_state !== 3'd4 && cyc < 1000) begin
         @(negedge baudclk); cyc++;
         if (ack[3]) req[3] = 1'b0;
      end
      req[1] = 1'b1;
      @(negedge baudclk);
      req[1] = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin @(negedge baudclk); cyc++; end
      saw_ack = 1'b0; saw_en = 1'b0; saw_busy = 1'b0;
      repeat (40) begin
         @(negedge baudclk);
         saw_ack |= ack[1]; saw_en |= tx_en; saw_busy |= busy;
      end
      total_cnt++;
      if (saw_ack !== 1'b0) $display("FAIL withdraw_ack: got %b want 0", saw_ack);
      else pass_cnt++;
      total_cnt++;
      if ({saw_en, saw_busy} !== 2'b00) $display("FAIL withdraw_idle: got en=%b busy=%b want 0 0", saw_en, saw_busy);
      else pass_cnt++;
      total_cnt++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL withdraw_byte: got n=%0d want D3", got_q.size());
      else pass_cnt++;
      got_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int cyc, n_ack;
      logic [NREQ-1:0] first_ack;
      req_data[15:8] = 8'hE1;
      exp_q.push_back(8'hE1);
      req[1] = 1'b1;
      cyc = 0;
      while (dbg_state !== 3'd3 && cyc < 500) begin
         @(negedge baudclk); cyc++;
         if (ack[1]) req[1] = 1'b0;
      end
      #1 reset = 1'b1;
      #1;
      total_cnt++;
      if ({tx_en, grant, ack, busy, tx_data, err} !== '0)
         $display("FAIL mid_reset_outputs: got %h want 0", {tx_en, grant, ack, busy, tx_data, err});
      else pass_cnt++;
      @(negedge baudclk); reset = 1'b0;
      total_cnt++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) $display("FAIL mid_reset_byte: got n=%0d want E1", got_q.size());
      else pass_cnt++;
      got_q.delete(); exp_q.delete();
      cyc = 0;
      while (tx_status !== 1'b1 && cyc < 400) begin @(negedge baudclk); cyc++; end
      repeat (4) @(negedge baudclk);
      req_data[15:8] = 8'hF1; req_data[31:24] = 8'hF3;
      exp_q = '{8'hF1, 8'hF3};
      req = 4'b1010;
      n_ack = 0; cyc = 0; first_ack = '0;
      while (n_ack < 2 && cyc < 2000) begin
         @(negedge baudclk); cyc++;
         if (|ack) begin
            if (n_ack == 0) first_ack = ack;
            n_ack++;
            req = req & ~ack;
         end
      end
      total_cnt++;
      if (first_ack !== 4'b0010) $display("FAIL mid_reset_pointer: got first ack %b want 0010", first_ack);
      else pass_cnt++;
      cyc = 0;
      while ((got_q.size() < 2 || busy) && cyc < 1000) begin @(negedge baudclk); cyc++; end
      for (int i = 0; i < 2; i++) begin
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL mid_reset_after%0d: got nothing want %h", i, exp_q[0]);
         else if (got_q[0] !== exp_q[0]) $display("FAIL mid_reset_after%0d: got %h want %h", i, got_q[0], exp_q[0]);
         else pass_cnt++;
         if (got_q.size() != 0) void'(got_q.pop_front());
         void'(exp_q.pop_front());
      end
      req = '0;
      got_q.delete(); exp_q.delete();
   endtask

`ifdef UART_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      sender_on = 1'b0;
      req_data[7:0] = 8'h77;
      req[0] = 1'b1;
      cyc = 0;
      while (err !== 1'b1 && cyc < 500) begin
         @(negedge baudclk); cyc++;
         if (ack[0]) req[0] = 1'b0;
      end
      total_cnt++;
      if ({err, tx_en, grant} !== {1'b1, 1'b0, 4'b0000})
         $display("FAIL timeout_err: got err=%b tx_en=%b grant=%b want 1 0 0000", err, tx_en, grant);
      else pass_cnt++;
      sender_on = 1'b1;
      cyc = 0;
      while (busy && cyc < 200) begin @(negedge baudclk); cyc++; end
      req_data[23:16] = 8'h78;
      exp_q.push_back(8'h78);
      req[2] = 1'b1;
      cyc = 0;
      while ((got_q.size() < 1 || busy) && cyc < 1000) begin
         @(negedge baudclk); cyc++;
         if (ack[2]) req[2] = 1'b0;
      end
      total_cnt++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0] || err !== 1'b1)
         $display("FAIL timeout_recover: got n=%0d err=%b want 1 byte 78 err 1", got_q.size(), err);
      else pass_cnt++;
      got_q.delete(); exp_q.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_withdraw();
      test_reset_mid();
`ifdef UART_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART byte sender among `NREQ` byte sources. It runs on the 16× oversampled `baudclk` and latches one byte from the granted requester. It drives the sender's `tx_en`/`tx_data` handshake, tracks the sender's idle/busy status through a synchronizer, and inserts a programmable idle gap between frames. An optional lock lets a requester send a multi-byte message without interleaving.

## Interface
- `NREQ`, 4: number of requesters, 2–8.
- `GAP_TICKS`, 16: `baudclk` cycles of enforced idle after each frame completes (≥1).
- `ACK_TIMEOUT`, 64: max `baudclk` cycles waiting for the sender to go busy (timeout build only).
- `DONE_TIMEOUT`, 256: max `baudclk` cycles waiting for the sender to return idle (timeout build only).

Ports:
- `baudclk` in 1: 16× baud clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in NREQ: requester i has a byte pending; held until its `ack`.
- `lock` in NREQ: requester i asks to keep the grant after the current byte.
- `req_data` in 8*NREQ: byte of requester i at bits [8i+7:8i].
- `ack` out NREQ: one-cycle pulse; byte of requester i latched.
- `grant` out NREQ: one-hot current owner; 0 when idle.
- `tx_data` out 8: byte presented to the sender.
- `tx_en` out 1: send request to the sender.
- `tx_status` in 1: sender idle (1) / busy (0); comes from another clock domain.
- `busy` out 1: arbiter not in IDLE.
- `err` out 1: sticky timeout flag.

## Operation
- `tx_status` passes through a 2-flop synchronizer (`st_s`, reset value 1). All decisions use `st_s`.
- Reset values: `tx_en`=0, `tx_data`=0, `grant`=0, `ack`=0, `busy`=0, `err`=0, round-robin pointer=0, state=IDLE, counters=0.
- States: IDLE, LOAD, WAIT_START, WAIT_DONE, GAP.
- **IDLE**
  - With any `req` and `st_s`=1: pick the winner, register `grant`, latch `tx_data`, pulse `ack[w]`, assert `tx_en`, and go to LOAD.
  - The pointer becomes (w+1) mod NREQ.
- **Winner selection:** the first set `req` bit searching upward from the pointer, wrapping around.
- **LOAD:** lasts one cycle, then go to WAIT_START. `tx_en` stays high.
- **WAIT_START:** hold `tx_en`=1 until `st_s`=0. Then drop `tx_en` in the same registered update and go to WAIT_DONE.
- **WAIT_DONE:** wait for `st_s`=1, then clear the gap counter and go to GAP.
- **GAP:** count `GAP_TICKS` cycles. At the end:
  - If `lock[g]` && `req[g]` for the current owner: latch its new byte, pulse `ack[g]`, assert `tx_en`, and go to LOAD. No arbitration; the pointer is unchanged.
  - Otherwise, clear `grant` and go to IDLE. Arbitration happens there on the next cycle.
- `req` dropped without `ack` simply withdraws the request. A byte already latched is still sent.
- `lock` is ignored unless its requester currently holds `grant`.
- `busy` = (state != IDLE).

## Timing
- From `req` rising in IDLE: `ack`, `grant` and `tx_en` rise 1 cycle later, all registered.
- `tx_en` falls 1 cycle after `st_s`=0 is seen, i.e. ≥3 cycles after it rose.
- Frame-to-frame spacing: sender frame time + 2 sync cycles + `GAP_TICKS` + 2 cycles.
- When several requests are pending, `ack` pulses are never closer than `GAP_TICKS`+4 cycles.
- Reset mid-operation drops `tx_en`/`grant` immediately. A sender frame already started completes on its own.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT_START and WAIT_DONE.
  - At `ACK_TIMEOUT` or `DONE_TIMEOUT` respectively: set `err` (sticky until reset), drop `tx_en`, clear `grant`, go to GAP, then IDLE. `lock` is ignored for that owner.
- Not defined: both states wait indefinitely, and `err` is tied 0.

## Structure
- Package `uart_arb_pkg`: state enum, `BYTE_W`=8, and the sync-stage count of 2.
- Sub-module `uart_rr_picker`: combinational. Takes `req` and the pointer, and returns a one-hot winner plus a valid flag.

## Test plan
- Single requester: `req[0]`, byte 0x55, sender model goes busy 2 cycles after `tx_en` and idle 160 cycles later. Expect:
  - `ack[0]` 1 cycle after `req`.
  - `tx_data`=0x55.
  - `tx_en` high until the synchronized busy is seen.
  - `busy` low `GAP_TICKS`+2 cycles after the sender goes idle.
- All four requesters held with bytes 0xA0..0xA3 → sent in order 0,1,2,3,0. The pointer wraps correctly.
- `lock[2]` with a 3-byte burst while `req[0]` is pending → bytes of requester 2 are sent back-to-back. Requester 0 follows after `lock[2]` drops.
- `req` withdrawn the cycle before arbitration → no `ack`, no `tx_en`, state stays IDLE.
- Timeout build: the sender never goes busy → `err`=1 at cycle `ACK_TIMEOUT`, `tx_en` drops, and the next requester is served normally.
- `reset` asserted in WAIT_DONE → all outputs return to reset values asynchronously. A new request after reset is served from pointer 0.
